pc_stack: RTL and testbench
===========================

// Module: pc_stack
// PURPOSE
//   Parametrised program counter for the downsampling processor, successor to the 8-bit PC.
//   Adds stall, PC-relative branch, and a hardware return-address stack (CALL/RET).
//   Sits between the control unit and the instruction memory address port.
//   addr_out is the address of the instruction being fetched.
// PARAMETERS
//   AW          8   address width in bits (>=2)
//   DEPTH       4   return-stack entries (>=1)
//   RESET_ADDR  0   value loaded into addr_out on reset (AW bits)
// PORTS
//   clk        in   1          clock; all state updates on rising edge
//   RST        in   1          synchronous, active-high reset
//   EN         in   1          1 = advance; 0 = stall, all state held
//   BRANCH     in   1          take branch to target
//   REL        in   1          qualifies BRANCH: 1 = PC-relative, 0 = absolute
//   CALL       in   1          push return address, jump absolute to addr_in
//   RET        in   1          pop top of stack into addr_out
//   addr_in    in   AW         branch target (absolute) or two's-complement offset (REL)
//   addr_out   out  AW         current instruction address (registered)
//   sp         out  clog2(DEPTH+1)  number of valid stack entries
//   stk_full   out  1          sp == DEPTH (combinational from sp)
//   stk_empty  out  1          sp == 0 (combinational from sp)
//   err        out  1          sticky: overflow/underflow occurred; cleared only by RST
// BEHAVIOUR
//   Reset (RST=1 at posedge, overrides everything):
//     addr_out=RESET_ADDR, sp=0, err=0; stack contents don't-care.
//   Next-state priority at each posedge, with RST=0:
//     RST > !EN > RET > CALL > BRANCH > increment.
//     Latency: one cycle; controls sampled at edge N, new addr_out visible after edge N.
//   EN=0: addr_out, sp, stack and err all hold; CALL/RET/BRANCH are ignored.
//   RET, sp>0:
//     addr_out <= stack[sp-1]; sp <= sp-1.
//   RET, sp==0 (underflow):
//     addr_out <= addr_out+1; sp stays 0; err <= 1.
//   CALL, sp<DEPTH:
//     stack[sp] <= addr_out+1 (mod 2^AW); addr_out <= addr_in; sp <= sp+1.
//   CALL, sp==DEPTH (overflow):
//     no push and no jump; addr_out <= addr_out+1; err <= 1.
//   BRANCH, REL=0:
//     addr_out <= addr_in.
//   BRANCH, REL=1:
//     addr_out <= addr_out + addr_in, with addr_in treated as signed AW-bit; result truncated to AW bits.
//   Otherwise:
//     addr_out <= addr_out+1.
//     Wraps from 2^AW-1 to 0 with no flag.
//   REL is ignored unless BRANCH is the winning action.
//   Simultaneous RET+CALL: only RET acts; CALL is dropped with no push and no err.
//   Simultaneous CALL+BRANCH: only CALL acts (absolute jump).
//   Reset mid-sequence (stack non-empty) discards all entries.
//   err is set only by overflow/underflow events and never self-clears.
// TESTING
//   1. RST pulse, then 5 idle cycles with EN=1 -> addr_out 0,1,2,3,4,5; sp=0; err=0.
//   2. AW=8, addr_out=8'hFF, no control -> next addr_out=8'h00, err stays 0.
//   3. addr_out=8'h10, BRANCH=1 REL=1 addr_in=8'hFC -> addr_out=8'h0C;
//      then REL=0 addr_in=8'h40 -> addr_out=8'h40.
//   4. At 8'h05 CALL addr_in=8'h20 -> addr_out=8'h20, sp=1;
//      3 increments, then RET -> addr_out=8'h06, sp=0, err=0.
//   5. DEPTH=4: 4 CALLs -> stk_full=1; 5th CALL at 8'h33 -> addr_out=8'h34, sp=4, err=1;
//      RET on empty stack -> increment, err=1.
//   6. EN=0 while CALL=1 and BRANCH=1 for 3 cycles -> addr_out and sp unchanged;
//      RST while sp=2 -> addr_out=RESET_ADDR, sp=0, stk_empty=1.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with stall, absolute/PC-relative branch and a hardware
// return-address stack; addr_out is the registered instruction-fetch address.
module pc_stack #(
    parameter int            AW         = 8,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         BRANCH,
    input  logic                         REL,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic [AW-1:0]                addr_in,
    output logic [AW-1:0]                addr_out,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         err
);

    localparam int SPW = $clog2(DEPTH+1);

    logic [AW-1:0]  stack [DEPTH];
    logic [AW-1:0]  pc_inc;
    logic [AW-1:0]  pc_nxt;
    logic [AW-1:0]  stk_top;
    logic [SPW-1:0] sp_nxt;
    logic           err_nxt;
    logic           push;

    assign stk_full  = (sp == SPW'(DEPTH));
    assign stk_empty = (sp == '0);
    assign pc_inc    = addr_out + AW'(1);

    // Mux-based read of the top entry keeps indexing free of width games
    // when DEPTH is not a power of two.
    always_comb begin
        stk_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) stk_top = stack[i];
        end
    end

    always_comb begin
        pc_nxt  = pc_inc;
        sp_nxt  = sp;
        err_nxt = err;
        push    = 1'b0;
        if (!EN) begin
            pc_nxt = addr_out;
        end else if (RET) begin
            if (stk_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt = stk_top;
                sp_nxt = sp - SPW'(1);
            end
        end else if (CALL) begin
            if (stk_full) begin
                err_nxt = 1'b1;
            end else begin
                push   = 1'b1;
                pc_nxt = addr_in;
                sp_nxt = sp + SPW'(1);
            end
        end else if (BRANCH) begin
            pc_nxt = REL ? (addr_out + addr_in) : addr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            addr_out <= RESET_ADDR;
            sp       <= '0;
            err      <= 1'b0;
        end else begin
            addr_out <= pc_nxt;
            sp       <= sp_nxt;
            err      <= err_nxt;
        end
    end

    // Stack contents carry no reset; sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!RST && push && (sp == SPW'(i))) stack[i] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based reference model.
module tb_pc_stack;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          RST, EN, BRANCH, REL, CALL, RET;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic [2:0]    sp;
    logic          stk_full, stk_empty, err;

    int checks   = 0;
    int failures = 0;

    pc_stack #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .RST(RST), .EN(EN), .BRANCH(BRANCH), .REL(REL),
        .CALL(CALL), .RET(RET), .addr_in(addr_in), .addr_out(addr_out),
        .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: PC as a byte, return stack as a queue.
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_err;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (RST) begin
            m_pc = 8'h00;
            m_stk.delete();
            m_err = 1'b0;
            m_valid = 1'b1;
        end else if (!EN) begin
            // hold
        end else if (RET) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
        end else if (CALL) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 8'd1);
                m_pc = addr_in;
            end else begin
                m_pc = m_pc + 8'd1;
                m_err = 1'b1;
            end
        end else if (BRANCH) begin
            if (REL) m_pc = 8'(int'(m_pc) + int'($signed(addr_in)));
            else     m_pc = addr_in;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("addr_out", int'(addr_out), int'(m_pc));
            chk("sp", int'(sp), m_stk.size());
            chk("stk_full", int'(stk_full), int'(m_stk.size() == DEPTH));
            chk("stk_empty", int'(stk_empty), int'(m_stk.size() == 0));
            chk("err", int'(err), int'(m_err));
        end
    end

    // Apply one cycle of controls; returns after the edge, at the negedge.
    task automatic cyc(input logic rst, input logic en, input logic ret, input logic call,
                       input logic br, input logic rel, input logic [7:0] a);
        RST = rst; EN = en; RET = ret; CALL = call; BRANCH = br; REL = rel; addr_in = a;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] pc, input int s, input logic e);
        chk({name, "_pc"}, int'(addr_out), int'(pc));
        chk({name, "_sp"}, int'(sp), s);
        chk({name, "_err"}, int'(err), int'(e));
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; RET = 1'b0; CALL = 1'b0; BRANCH = 1'b0; REL = 1'b0; addr_in = '0;
        @(negedge clk);
        lit("reset", 8'h00, 0, 1'b0);
        chk("reset_empty", int'(stk_empty), 1);

        // idle count
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 8'h00);
            lit("idle", 8'(i), 0, 1'b0);
        end

        // wrap
        cyc(0, 1, 0, 0, 1, 0, 8'hFF);
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        lit("wrap", 8'h00, 0, 1'b0);

        // branches
        cyc(0, 1, 0, 0, 1, 0, 8'h10);
        cyc(0, 1, 0, 0, 1, 1, 8'hFC);
        lit("rel_back", 8'h0C, 0, 1'b0);
        cyc(0, 1, 0, 0, 1, 0, 8'h40);
        lit("abs", 8'h40, 0, 1'b0);

        // call / return
        cyc(0, 1, 0, 0, 1, 0, 8'h05);
        cyc(0, 1, 0, 1, 0, 0, 8'h20);
        lit("call", 8'h20, 1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        lit("ret", 8'h06, 0, 1'b0);

        // overflow / underflow
        cyc(0, 1, 0, 1, 0, 0, 8'h50);
        cyc(0, 1, 0, 1, 0, 0, 8'h60);
        cyc(0, 1, 0, 1, 0, 0, 8'h70);
        cyc(0, 1, 0, 1, 0, 0, 8'h30);
        chk("full", int'(stk_full), 1);
        cyc(0, 1, 0, 0, 1, 0, 8'h33);
        cyc(0, 1, 0, 1, 0, 0, 8'h80);
        lit("overflow", 8'h34, 4, 1'b1);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        lit("pop3", 8'h71, 3, 1'b1);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        lit("pop0", 8'h07, 0, 1'b1);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        lit("underflow", 8'h08, 0, 1'b1);

        // stall, then reset with live entries
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 1, 0, 0, 8'h40);
        cyc(0, 1, 0, 1, 0, 0, 8'h90);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 0, 8'hAA);
            lit("stall", 8'h90, 2, 1'b0);
        end
        cyc(1, 1, 0, 1, 0, 0, 8'h55);
        lit("rst_mid", 8'h00, 0, 1'b0);
        chk("rst_empty", int'(stk_empty), 1);

        // simultaneous controls
        cyc(0, 1, 0, 1, 0, 0, 8'h10);
        cyc(0, 1, 1, 1, 0, 0, 8'h77);
        lit("ret_call", 8'h01, 0, 1'b0);
        cyc(0, 1, 0, 1, 1, 1, 8'h22);
        lit("call_br", 8'h22, 1, 1'b0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(7) != 0),
                ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                ($urandom_range(2) == 0), 1'($urandom_range(1)),
                8'($urandom_range(255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
